// File: rtl/subtractor_serial_4bit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// subtractor_serial_4bit : bit-serial a - b, LSB first, borrow in diff[WIDTH]
// Rev 1.0
// ---------------------------------------------------------------------------
module subtractor_serial_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   diff
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   diff_q, diff_d;

  logic d_bit;
  logic br_next;

  assign d_bit   = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
  assign br_next = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    part_d  = part_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          part_d  = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Result bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
        part_d = {d_bit, part_q[WIDTH-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = br_next;
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          diff_d  = {br_next, d_bit, part_q[WIDTH-1:1]};
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      part_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      part_q  <= part_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign diff = diff_q;

endmodule
`default_nettype wire

// File: tb/tb_subtractor_serial_4bit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_subtractor_serial_4bit : directed vectors plus exhaustive sweep
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_subtractor_serial_4bit;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   diff;

  int n_vec = 0;
  int n_err = 0;

  subtractor_serial_4bit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the done cycle (IDLE).
  task automatic run_op(input logic [3:0] va, input logic [3:0] vb, input logic [4:0] exp);
    int lat;
    int nbusy;
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);
    lat = 0;
    nbusy = 0;
    for (int k = 0; k < 12 && !done; k++) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    chk("done_seen", {7'b0, done}, 8'd1);
    chk("busy_in_done", {7'b0, busy}, 8'd0);
    // done rises on the WIDTH-th edge after the accept edge (5th counting it).
    chk("latency", 8'(lat), 8'(WIDTH));
    chk("busy_cycles", 8'(nbusy), 8'(WIDTH));
    chk("diff", {3'b0, diff}, {3'b0, exp});
    @(negedge clk);
    chk("done_pulse", {7'b0, done}, 8'd0);
  endtask

  initial begin
    int bad;
    logic [4:0] ref_d;

    // Reset
    #2;
    chk("rst_busy", {7'b0, busy}, 8'd0);
    chk("rst_done", {7'b0, done}, 8'd0);
    chk("rst_diff", {3'b0, diff}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy || done || diff != 5'd0) bad++;
    end
    chk("idle_quiet", 8'(bad), 8'd0);

    // Basic and underflow
    run_op(4'd9, 4'd3, 5'b00110);
    run_op(4'd15, 4'd15, 5'b00000);
    run_op(4'd3, 4'd9, 5'b11010);
    run_op(4'd0, 4'd1, 5'b11111);

    // Start ignored while busy and in done
    a = 4'd8;
    b = 4'd2;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd1;
    b = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 12 && !done; k++) @(negedge clk);
    chk("ign_done", {7'b0, done}, 8'd1);
    chk("ign_diff", {3'b0, diff}, 8'b00110);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (busy || done) bad++;
      @(negedge clk);
    end
    chk("ign_no_second", 8'(bad), 8'd0);
    chk("ign_diff_hold", {3'b0, diff}, 8'b00110);

    // Abort by asynchronous reset in the 2nd busy cycle
    a = 4'd12;
    b = 4'd5;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {7'b0, busy}, 8'd0);
    chk("abort_done", {7'b0, done}, 8'd0);
    chk("abort_diff", {3'b0, diff}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy || done) bad++;
    end
    chk("abort_idle", 8'(bad), 8'd0);
    run_op(4'd12, 4'd5, 5'b00111);

    // Back-to-back exhaustive sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        ref_d = {(ia < ib) ? 1'b1 : 1'b0, 4'(ia - ib)};
        run_op(4'(ia), 4'(ib), ref_d);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
